// File: rtl/bsg_path_accel_ctrl.sv
// Path-planning accelerator job controller: collects header + map rows, validates, runs the engine with a timeout.
// Latency: CHECK one cycle after last row, result one cycle after done/timeout; input stalls (ready_o=0) outside HDR/ROWS, result held until yumi_i.
module bsg_path_accel_ctrl #(
    parameter int board_width_p = 8,
    parameter int max_cycles_p  = 4096,
    localparam int coord_width_lp = (board_width_p > 1) ? $clog2(board_width_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [63:0]                            data_i,
    input  logic                                   v_i,
    output logic                                   ready_o,
    output logic [63:0]                            data_o,
    output logic                                   v_o,
    input  logic                                   yumi_i,
    output logic                                   eng_start_o,
    output logic                                   eng_abort_o,
    output logic [board_width_p*board_width_p-1:0] eng_map_o,
    output logic [coord_width_lp-1:0]              eng_start_x_o,
    output logic [coord_width_lp-1:0]              eng_start_y_o,
    output logic [coord_width_lp-1:0]              eng_goal_x_o,
    output logic [coord_width_lp-1:0]              eng_goal_y_o,
    input  logic                                   eng_done_i,
    input  logic                                   eng_found_i,
    input  logic [15:0]                            eng_len_i
);

    localparam int cells_lp = board_width_p * board_width_p;
    localparam int idx_w_lp = $clog2(cells_lp);

    typedef enum logic [2:0] {
        S_HDR,
        S_ROWS,
        S_CHECK,
        S_RUN,
        S_RESULT
    } state_e;

    state_e                    state_q;
    logic [7:0]                sx_q, sy_q, gx_q, gy_q;
    logic [cells_lp-1:0]       map_q;
    logic [coord_width_lp-1:0] row_cnt_q;
    logic [15:0]               cyc_cnt_q;
    logic [15:0]               cyc_cnt_d;
    logic [63:0]               result_q;

    logic                      xfer;
    logic                      last_row;
    logic                      coords_ok;
    logic [idx_w_lp-1:0]       s_idx, g_idx;
    logic                      start_blk, goal_blk;
    logic                      bad_job;
    logic                      timeout_hit;
    logic                      unused_hdr;

    assign ready_o     = (state_q == S_HDR) || (state_q == S_ROWS);
    assign v_o         = (state_q == S_RESULT);
    assign data_o      = result_q;
    assign xfer        = v_i & ready_o;
    assign last_row    = (row_cnt_q == coord_width_lp'(board_width_p - 1));
    assign unused_hdr  = ^data_i[63:32];

    // Range check uses the full 8-bit fields; the engine only sees truncated coordinates.
    assign coords_ok = (32'(sx_q) < board_width_p) && (32'(sy_q) < board_width_p) &&
                       (32'(gx_q) < board_width_p) && (32'(gy_q) < board_width_p);

    assign s_idx = idx_w_lp'(32'(sy_q[coord_width_lp-1:0]) * board_width_p + 32'(sx_q[coord_width_lp-1:0]));
    assign g_idx = idx_w_lp'(32'(gy_q[coord_width_lp-1:0]) * board_width_p + 32'(gx_q[coord_width_lp-1:0]));

    assign start_blk = coords_ok ? map_q[s_idx] : 1'b0;
    assign goal_blk  = coords_ok ? map_q[g_idx] : 1'b0;
    assign bad_job   = !coords_ok || start_blk || goal_blk;

    assign cyc_cnt_d   = (cyc_cnt_q == 16'hFFFF) ? cyc_cnt_q : cyc_cnt_q + 16'd1;
    assign timeout_hit = (32'(cyc_cnt_q) == max_cycles_p);

    // Engine pulses are decoded from the current state so they land in the CHECK / timeout cycle itself.
    assign eng_start_o = (state_q == S_CHECK) && !bad_job;
    assign eng_abort_o = (state_q == S_RUN) && !eng_done_i && timeout_hit;

    assign eng_map_o     = map_q;
    assign eng_start_x_o = sx_q[coord_width_lp-1:0];
    assign eng_start_y_o = sy_q[coord_width_lp-1:0];
    assign eng_goal_x_o  = gx_q[coord_width_lp-1:0];
    assign eng_goal_y_o  = gy_q[coord_width_lp-1:0];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_HDR;
            sx_q      <= '0;
            sy_q      <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            map_q     <= '0;
            row_cnt_q <= '0;
            cyc_cnt_q <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_HDR: begin
                    if (xfer) begin
                        sx_q      <= data_i[31:24];
                        sy_q      <= data_i[23:16];
                        gx_q      <= data_i[15:8];
                        gy_q      <= data_i[7:0];
                        row_cnt_q <= '0;
                        state_q   <= S_ROWS;
                    end
                end
                S_ROWS: begin
                    if (xfer) begin
                        map_q[32'(row_cnt_q)*board_width_p +: board_width_p] <= data_i[board_width_p-1:0];
                        row_cnt_q <= row_cnt_q + 1'b1;
                        if (last_row) begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (bad_job) begin
                        result_q  <= {2'b11, 62'b0};
                        cyc_cnt_q <= '0;
                        state_q   <= S_RESULT;
                    end else begin
                        cyc_cnt_q <= 16'd1;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    cyc_cnt_q <= cyc_cnt_d;
                    if (eng_done_i) begin
                        result_q <= {(eng_found_i ? 2'b00 : 2'b01), 30'b0, cyc_cnt_q,
                                     (eng_found_i ? eng_len_i : 16'h0000)};
                        state_q  <= S_RESULT;
                    end else if (timeout_hit) begin
                        result_q <= {2'b10, 30'b0, cyc_cnt_q, 16'h0000};
                        state_q  <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (yumi_i) begin
                        state_q <= S_HDR;
                    end
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_path_accel_ctrl.sv
// Scoreboard bench for bsg_path_accel_ctrl (W=8, timeout 64): directed jobs push expected results, a monitor checks them on acceptance.
module tb_bsg_path_accel_ctrl;

    logic        clk;
    logic        reset_n_i;
    logic [63:0] data_i;
    logic        v_i;
    logic        ready_o;
    logic [63:0] data_o;
    logic        v_o;
    logic        yumi_i;
    logic        eng_start_o;
    logic        eng_abort_o;
    logic [63:0] eng_map_o;
    logic [2:0]  eng_start_x_o, eng_start_y_o, eng_goal_x_o, eng_goal_y_o;
    logic        eng_done_i;
    logic        eng_found_i;
    logic [15:0] eng_len_i;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    bsg_path_accel_ctrl #(.board_width_p(8), .max_cycles_p(64)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
        .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .eng_start_o(eng_start_o),
        .eng_abort_o(eng_abort_o), .eng_map_o(eng_map_o), .eng_start_x_o(eng_start_x_o),
        .eng_start_y_o(eng_start_y_o), .eng_goal_x_o(eng_goal_x_o), .eng_goal_y_o(eng_goal_y_o),
        .eng_done_i(eng_done_i), .eng_found_i(eng_found_i), .eng_len_i(eng_len_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, req);
        end
    endtask

    // Monitor: compare each accepted result against the oldest expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset_n_i && v_o && yumi_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", data_o, 64'hx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", data_o, e);
            end
        end
    end

    function automatic logic [63:0] hdr(input logic [7:0] sx, sy, gx, gy);
        return {32'hDEAD_BEEF, sx, sy, gx, gy};
    endfunction

    // All tasks start and end 1ns after a rising edge.
    task automatic send_word(input logic [63:0] d, input int gap);
        bit done = 0;
        repeat (gap) begin @(posedge clk); #1; end
        v_i = 1'b1;
        data_i = d;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (ready_o) done = 1;
            @(posedge clk); #1;
        end
        if (!done) chk("send_word_timeout", 64'd0, 64'd1);
        v_i = 1'b0;
    endtask

    task automatic send_job(input logic [7:0] sx, sy, gx, gy, input logic [63:0] map, input int gap);
        send_word(hdr(sx, sy, gx, gy), gap);
        for (int r = 0; r < 8; r++) send_word({56'hA5A5_A5A5_A5A5_A5, map[r*8 +: 8]}, gap);
    endtask

    // Called in the CHECK cycle; raises done during RUN cycle done_cycle.
    task automatic run_engine(input int done_cycle, input logic found, input logic [15:0] len);
        @(negedge clk);
        chk("eng_start_pulse", {63'd0, eng_start_o}, 64'd1);
        repeat (done_cycle) begin @(posedge clk); #1; end
        eng_done_i  = 1'b1;
        eng_found_i = found;
        eng_len_i   = len;
        @(negedge clk);
        chk("no_abort_on_done", {63'd0, eng_abort_o}, 64'd0);
        @(posedge clk); #1;
        eng_done_i = 1'b0;
        @(negedge clk);
        chk("v_o_after_done", {63'd0, v_o}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_timeout();
        @(negedge clk);
        chk("eng_start_pulse_to", {63'd0, eng_start_o}, 64'd1);
        repeat (63) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("abort_cycle63", {63'd0, eng_abort_o}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_cycle64", {63'd0, eng_abort_o}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("v_o_after_timeout", {63'd0, v_o}, 64'd1);
        chk("abort_single_pulse", {63'd0, eng_abort_o}, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic bad_job_check();
        @(negedge clk);
        chk("bad_no_start", {63'd0, eng_start_o}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bad_v_o_t2", {63'd0, v_o}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic take_result(input int hold, input logic [63:0] req);
        for (int n = 0; n < 100 && !v_o; n++) begin @(posedge clk); #1; end
        chk("v_o_wait", {63'd0, v_o}, 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_data_stable", data_o, req);
            chk("hold_ready_low", {63'd0, ready_o}, 64'd0);
            @(posedge clk); #1;
        end
        yumi_i = 1'b1;
        @(posedge clk); #1;
        yumi_i = 1'b0;
        @(negedge clk);
        chk("hdr_ready_after_yumi", {62'd0, ready_o, v_o}, 64'd2);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 1'b0; v_i = 1'b0; data_i = '0; yumi_i = 1'b0;
        eng_done_i = 1'b0; eng_found_i = 1'b0; eng_len_i = '0;
        #2;
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_v_o", {63'd0, v_o}, 64'd0);
        chk("rst_data_o", data_o, 64'd0);
        chk("rst_pulses", {62'd0, eng_start_o, eng_abort_o}, 64'd0);
        chk("rst_map", eng_map_o, 64'd0);
        @(posedge clk); #1;
        reset_n_i = 1'b1;

        // Clear map, found path.
        send_job(8'd0, 8'd0, 8'd7, 8'd7, 64'd0, 0);
        chk("coord_goal", {58'd0, eng_goal_x_o, eng_goal_y_o}, 64'h3F);
        chk("coord_start", {58'd0, eng_start_x_o, eng_start_y_o}, 64'h0);
        exp_q.push_back(64'h0000_0000_0005_000F);
        run_engine(5, 1'b1, 16'd15);
        take_result(0, 64'h0000_0000_0005_000F);

        // Same job, no path: length suppressed.
        send_job(8'd0, 8'd0, 8'd7, 8'd7, 64'd0, 0);
        exp_q.push_back(64'h4000_0000_0005_0000);
        run_engine(5, 1'b0, 16'd15);
        take_result(0, 64'h4000_0000_0005_0000);

        // Timeout at 64 RUN cycles.
        send_job(8'd0, 8'd0, 8'd7, 8'd7, 64'd0, 0);
        exp_q.push_back(64'h8000_0000_0040_0000);
        run_timeout();
        take_result(0, 64'h8000_0000_0040_0000);

        // gx out of range.
        send_job(8'd0, 8'd0, 8'd8, 8'd7, 64'd0, 0);
        exp_q.push_back(64'hC000_0000_0000_0000);
        bad_job_check();
        take_result(0, 64'hC000_0000_0000_0000);

        // Start cell (2,3) blocked.
        send_job(8'd2, 8'd3, 8'd7, 8'd7, 64'h0000_0000_0400_0000, 0);
        chk("coord_start_23", {58'd0, eng_start_x_o, eng_start_y_o}, 64'h13);
        exp_q.push_back(64'hC000_0000_0000_0000);
        bad_job_check();
        take_result(0, 64'hC000_0000_0000_0000);

        // Gapped rows, consumer stalls 10 cycles.
        send_job(8'd0, 8'd0, 8'd7, 8'd7, 64'h0042_0008_0020_1000, 2);
        chk("gapped_map", eng_map_o, 64'h0042_0008_0020_1000);
        exp_q.push_back(64'h0000_0000_0003_000C);
        run_engine(3, 1'b1, 16'd12);
        take_result(10, 64'h0000_0000_0003_000C);

        // Done in the timeout cycle: done wins.
        send_job(8'd0, 8'd0, 8'd7, 8'd7, 64'd0, 0);
        exp_q.push_back(64'h0000_0000_0040_0014);
        run_engine(64, 1'b1, 16'd20);
        take_result(0, 64'h0000_0000_0040_0014);

        // Reset mid-ROWS, then a full job.
        send_word(hdr(8'd1, 8'd1, 8'd6, 8'd5), 0);
        for (int r = 0; r < 3; r++) send_word(64'h3C, 0);
        #2 reset_n_i = 1'b0;
        #1;
        chk("rows_rst_ready_v", {62'd0, ready_o, v_o}, 64'd2);
        chk("rows_rst_map", eng_map_o, 64'd0);
        chk("rows_rst_coord", {61'd0, eng_start_x_o}, 64'd0);
        chk("rows_rst_data", data_o, 64'd0);
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        send_job(8'd1, 8'd1, 8'd6, 8'd5, 64'h00FF_0000_0000_0000, 0);
        exp_q.push_back(64'h0000_0000_0004_0009);
        run_engine(4, 1'b1, 16'd9);
        take_result(0, 64'h0000_0000_0004_0009);

        // Reset mid-RUN, then a full job.
        send_job(8'd0, 8'd0, 8'd7, 8'd7, 64'd0, 0);
        repeat (10) begin @(posedge clk); #1; end
        #2 reset_n_i = 1'b0;
        #1;
        chk("run_rst_pulses", {62'd0, eng_start_o, eng_abort_o}, 64'd0);
        chk("run_rst_ready_v", {62'd0, ready_o, v_o}, 64'd2);
        chk("run_rst_data", data_o, 64'd0);
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        send_job(8'd0, 8'd0, 8'd7, 8'd7, 64'd0, 0);
        exp_q.push_back(64'h0000_0000_0002_0001);
        run_engine(2, 1'b1, 16'd1);
        take_result(0, 64'h0000_0000_0002_0001);

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
